m14k_ssram_fill_ctl: RTL and testbench

Write/read port sequencer placed directly upstream of the single-ported, byte-writable cache data SRAM. It arbitrates cache line refills from the BIU, CPU store writes and CPU line reads onto the SRAM's one index/strobe/mask/data port. It produces only registered, never-X strobes and masks. Refill words arrive critical-word-first and are written one word per cycle with wrap-around.

---
 rtl/m14k_ssram_fill_ctl.sv | 204 ++++++++++++++++++++
 tb/tb_m14k_ssram_fill_ctl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m14k_ssram_fill_ctl.sv
// -----------------------------------------------------------------------------
// m14k_ssram_fill_ctl
//
// Port sequencer in front of the single-ported, byte-writable cache data SRAM.
// Arbitrates BIU line refills, CPU stores and CPU line reads onto the SRAM's
// one index/strobe/mask/data port. Refill words arrive critical-word-first and
// are written one per cycle with wrap-around inside the line. Every output is
// registered and reset to zero, so the SRAM never sees an X strobe or mask.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   fill_req/idx/start          refill request, target line, critical word
//   fill_ack                    pulse: refill accepted
//   fill_word_valid/data/err    refill word stream from the BIU
//   fill_done, fill_err         pulse: refill finished (err = aborted)
//   st_req/idx/word/be/data     store request
//   st_ack                      pulse: store accepted
//   rd_req/idx                  line read request
//   rd_ack                      pulse: read accepted
//   busy                        refill in progress
//   sram_line_idx               SRAM line index
//   sram_wr_mask                SRAM byte write mask (one bit per byte of line)
//   sram_rd_str, sram_wr_str    SRAM read / write strobes
//   sram_wr_data                write word, replicated across the line by SRAM
// -----------------------------------------------------------------------------
module m14k_ssram_fill_ctl #(
   parameter int LIdxSize       = 2,
   parameter int WordsPerLine   = 4,
   parameter int BYTES_PER_WORD = 4,
   parameter int WORD_WIDTH     = 8 * BYTES_PER_WORD,
   parameter int BYTES_PER_LINE = BYTES_PER_WORD * WordsPerLine
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            fill_req,
   input  logic [LIdxSize-1:0]             fill_idx,
   input  logic [$clog2(WordsPerLine)-1:0] fill_start,
   output logic                            fill_ack,
   input  logic                            fill_word_valid,
   input  logic [WORD_WIDTH-1:0]           fill_word_data,
   input  logic                            fill_word_err,
   output logic                            fill_done,
   output logic                            fill_err,
   input  logic                            st_req,
   input  logic [LIdxSize-1:0]             st_idx,
   input  logic [$clog2(WordsPerLine)-1:0] st_word,
   input  logic [BYTES_PER_WORD-1:0]       st_be,
   input  logic [WORD_WIDTH-1:0]           st_data,
   output logic                            st_ack,
   input  logic                            rd_req,
   input  logic [LIdxSize-1:0]             rd_idx,
   output logic                            rd_ack,
   output logic                            busy,
   output logic [LIdxSize-1:0]             sram_line_idx,
   output logic [BYTES_PER_LINE-1:0]       sram_wr_mask,
   output logic                            sram_rd_str,
   output logic                            sram_wr_str,
   output logic [WORD_WIDTH-1:0]           sram_wr_data
);

   localparam int WIDX = $clog2(WordsPerLine);
   // cnt must reach WordsPerLine, so it is one bit wider than a word index.
   localparam int CW = $clog2(WordsPerLine + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WordsPerLine - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [LIdxSize-1:0] lidx_q, lidx_d;
   logic [WIDX-1:0]     start_q, start_d;
   logic [WIDX-1:0]     fill_w;

   logic                      fill_ack_d, fill_done_d, fill_err_d;
   logic                      st_ack_d, rd_ack_d, busy_d;
   logic                      rd_str_d, wr_str_d;
   logic [LIdxSize-1:0]       line_idx_d;
   logic [BYTES_PER_LINE-1:0] mask_d;
   logic [WORD_WIDTH-1:0]     wr_data_d;

   // Next state and next (registered) outputs.
   always_comb begin
      // NOTE: every signal gets a default before any branch; a path that
      // leaves one unassigned would infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      lidx_d      = lidx_q;
      start_d     = start_q;
      fill_ack_d  = 1'b0;
      fill_done_d = 1'b0;
      fill_err_d  = 1'b0;
      st_ack_d    = 1'b0;
      rd_ack_d    = 1'b0;
      rd_str_d    = 1'b0;
      wr_str_d    = 1'b0;
      mask_d      = '0;
      // Index and data hold their last value unless a strobe is driven.
      line_idx_d  = sram_line_idx;
      wr_data_d   = sram_wr_data;
      // Critical-word-first wrap: the WIDX-bit sum drops the carry.
      fill_w      = start_q + cnt_q[WIDX-1:0];

      case (state_q)
         IDLE: begin
            if (fill_req) begin
               lidx_d     = fill_idx;
               start_d    = fill_start;
               cnt_d      = '0;
               state_d    = FILL;
               fill_ack_d = 1'b1;
            end else if (st_req) begin
               st_ack_d = 1'b1;
               // An all-zero byte enable is acked but touches nothing.
               if (|st_be) begin
                  wr_str_d   = 1'b1;
                  line_idx_d = st_idx;
                  wr_data_d  = st_data;
                  mask_d[st_word * BYTES_PER_WORD +: BYTES_PER_WORD] = st_be;
               end
            end else if (rd_req) begin
               rd_ack_d   = 1'b1;
               rd_str_d   = 1'b1;
               line_idx_d = rd_idx;
            end
         end

         FILL: begin
            if (fill_word_valid) begin
               if (fill_word_err) begin
                  // Abort: words already written stay; tag logic invalidates.
                  fill_done_d = 1'b1;
                  fill_err_d  = 1'b1;
                  state_d     = IDLE;
               end else begin
                  wr_str_d   = 1'b1;
                  line_idx_d = lidx_q;
                  wr_data_d  = fill_word_data;
                  mask_d[fill_w * BYTES_PER_WORD +: BYTES_PER_WORD] = '1;
                  cnt_d      = cnt_q + 1'b1;
                  if (cnt_q == LAST_CNT) begin
                     fill_done_d = 1'b1;
                     state_d     = IDLE;
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase

      // busy covers the whole fill, including the fill_done cycle.
      busy_d = (state_d == FILL) || fill_done_d;
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is assigned with non-blocking (<=) so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lidx_q  <= '0;
         start_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lidx_q  <= lidx_d;
         start_q <= start_d;
      end
   end

   // Output registers: reset clears everything, including index and data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill_ack      <= 1'b0;
         fill_done     <= 1'b0;
         fill_err      <= 1'b0;
         st_ack        <= 1'b0;
         rd_ack        <= 1'b0;
         busy          <= 1'b0;
         sram_rd_str   <= 1'b0;
         sram_wr_str   <= 1'b0;
         sram_wr_mask  <= '0;
         sram_line_idx <= '0;
         sram_wr_data  <= '0;
      end else begin
         fill_ack      <= fill_ack_d;
         fill_done     <= fill_done_d;
         fill_err      <= fill_err_d;
         st_ack        <= st_ack_d;
         rd_ack        <= rd_ack_d;
         busy          <= busy_d;
         sram_rd_str   <= rd_str_d;
         sram_wr_str   <= wr_str_d;
         sram_wr_mask  <= mask_d;
         sram_line_idx <= line_idx_d;
         sram_wr_data  <= wr_data_d;
      end
   end

endmodule

// File: tb/tb_m14k_ssram_fill_ctl.sv
// -----------------------------------------------------------------------------
// tb_m14k_ssram_fill_ctl
//
// Table-driven bench: each record holds one cycle of inputs and the outputs
// expected in the following cycle. A small byte-lane SRAM model collects the
// writes so line contents can be checked, and a negedge monitor checks the
// port invariants every cycle. Reset abort is a hand-written sequence.
// -----------------------------------------------------------------------------
module tb_m14k_ssram_fill_ctl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fill_req = 1'b0;
   logic [1:0]  fill_idx = '0;
   logic [1:0]  fill_start = '0;
   logic        fill_ack;
   logic        fill_word_valid = 1'b0;
   logic [31:0] fill_word_data = '0;
   logic        fill_word_err = 1'b0;
   logic        fill_done;
   logic        fill_err;
   logic        st_req = 1'b0;
   logic [1:0]  st_idx = '0;
   logic [1:0]  st_word = '0;
   logic [3:0]  st_be = '0;
   logic [31:0] st_data = '0;
   logic        st_ack;
   logic        rd_req = 1'b0;
   logic [1:0]  rd_idx = '0;
   logic        rd_ack;
   logic        busy;
   logic [1:0]  sram_line_idx;
   logic [15:0] sram_wr_mask;
   logic        sram_rd_str;
   logic        sram_wr_str;
   logic [31:0] sram_wr_data;

   m14k_ssram_fill_ctl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .fill_req        (fill_req),
      .fill_idx        (fill_idx),
      .fill_start      (fill_start),
      .fill_ack        (fill_ack),
      .fill_word_valid (fill_word_valid),
      .fill_word_data  (fill_word_data),
      .fill_word_err   (fill_word_err),
      .fill_done       (fill_done),
      .fill_err        (fill_err),
      .st_req          (st_req),
      .st_idx          (st_idx),
      .st_word         (st_word),
      .st_be           (st_be),
      .st_data         (st_data),
      .st_ack          (st_ack),
      .rd_req          (rd_req),
      .rd_idx          (rd_idx),
      .rd_ack          (rd_ack),
      .busy            (busy),
      .sram_line_idx   (sram_line_idx),
      .sram_wr_mask    (sram_wr_mask),
      .sram_rd_str     (sram_rd_str),
      .sram_wr_str     (sram_wr_str),
      .sram_wr_data    (sram_wr_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        fill_req;
      logic [1:0]  fill_idx;
      logic [1:0]  fill_start;
      logic        fwv;
      logic [31:0] fwd;
      logic        fwe;
      logic        st_req;
      logic [1:0]  st_idx;
      logic [1:0]  st_word;
      logic [3:0]  st_be;
      logic [31:0] st_data;
      logic        rd_req;
      logic [1:0]  rd_idx;
   } in_t;

   typedef struct packed {
      logic [7:0]  flags;  // {fill_ack, fill_done, fill_err, st_ack, rd_ack, busy, rd_str, wr_str}
      logic [15:0] mask;
      logic [1:0]  idx;
      logic [31:0] data;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   localparam logic [7:0] F_ACK  = 8'b1000_0000;
   localparam logic [7:0] F_DONE = 8'b0100_0000;
   localparam logic [7:0] F_ERR  = 8'b0010_0000;
   localparam logic [7:0] S_ACK  = 8'b0001_0000;
   localparam logic [7:0] R_ACK  = 8'b0000_1000;
   localparam logic [7:0] BUSY   = 8'b0000_0100;
   localparam logic [7:0] RD     = 8'b0000_0010;
   localparam logic [7:0] WR     = 8'b0000_0001;

   localparam logic [31:0] A0 = 32'h1111_A0A0, A1 = 32'h2222_A1A1;
   localparam logic [31:0] A2 = 32'h3333_A2A2, A3 = 32'h4444_A3A3;
   localparam logic [31:0] B0 = 32'hB000_0000, B1 = 32'hB000_0001;
   localparam logic [31:0] B2 = 32'hB000_0002, B3 = 32'hB000_0003;
   localparam logic [31:0] SD = 32'h5A5A_C3C3, DD = 32'hD1D2_D3D4;
   localparam logic [31:0] C0 = 32'hC0C0_C0C0, C1 = 32'hC1C1_C1C1;

   int errors = 0;
   int checks = 0;
   bit inv_en = 1'b0;
   logic [127:0] line_mem [4];
   vec_t tbl [$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic in_t f_req(input logic [1:0] idx, input logic [1:0] start);
      in_t r = '0;
      r.fill_req = 1'b1; r.fill_idx = idx; r.fill_start = start;
      return r;
   endfunction

   function automatic in_t f_word(input logic [31:0] d, input logic e);
      in_t r = '0;
      r.fwv = 1'b1; r.fwd = d; r.fwe = e;
      return r;
   endfunction

   function automatic in_t s_req(input logic [1:0] idx, input logic [1:0] word,
                                 input logic [3:0] be, input logic [31:0] d);
      in_t r = '0;
      r.st_req = 1'b1; r.st_idx = idx; r.st_word = word; r.st_be = be; r.st_data = d;
      return r;
   endfunction

   function automatic in_t r_req(input logic [1:0] idx);
      in_t r = '0;
      r.rd_req = 1'b1; r.rd_idx = idx;
      return r;
   endfunction

   function automatic out_t ex(input logic [7:0] f, input logic [15:0] m,
                               input logic [1:0] idx, input logic [31:0] d);
      out_t r;
      r.flags = f; r.mask = m; r.idx = idx; r.data = d;
      return r;
   endfunction

   function automatic out_t sample();
      out_t r;
      r.flags = {fill_ack, fill_done, fill_err, st_ack, rd_ack, busy, sram_rd_str, sram_wr_str};
      r.mask  = sram_wr_mask;
      r.idx   = sram_line_idx;
      r.data  = sram_wr_data;
      return r;
   endfunction

   task automatic apply(input in_t v);
      fill_req        = v.fill_req;
      fill_idx        = v.fill_idx;
      fill_start      = v.fill_start;
      fill_word_valid = v.fwv;
      fill_word_data  = v.fwd;
      fill_word_err   = v.fwe;
      st_req          = v.st_req;
      st_idx          = v.st_idx;
      st_word         = v.st_word;
      st_be           = v.st_be;
      st_data         = v.st_data;
      rd_req          = v.rd_req;
      rd_idx          = v.rd_idx;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Byte-lane SRAM model plus per-cycle port invariants, sampled mid-cycle.
   always @(negedge clk) begin
      if (inv_en) begin
         check("invariants", {61'd0, sram_rd_str & sram_wr_str,
                              ~sram_wr_str & (|sram_wr_mask),
                              $isunknown(sample())}, 64'd0);
         if (sram_wr_str === 1'b1)
            for (int b = 0; b < 16; b++)
               if (sram_wr_mask[b])
                  line_mem[sram_line_idx][8*b +: 8] = sram_wr_data[8*(b%4) +: 8];
      end
   end

   initial begin
      for (int l = 0; l < 4; l++) line_mem[l] = '0;

      // ---- reset and idle ----
      rst_n = 1'b0;
      apply('0);
      step();
      inv_en = 1'b1;
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         check($sformatf("idle_after_reset_%0d", c), 64'(sample()), 64'(ex(8'h00, 16'h0, 2'd0, 32'h0)));
      end

      // ---- refill line 2, critical word 2, then read it ----
      tbl.push_back({f_req(2'd2, 2'd2),             ex(F_ACK | BUSY,       16'h0000, 2'd0, 32'h0)});
      tbl.push_back({f_word(A0, 1'b0),              ex(BUSY | WR,          16'h0F00, 2'd2, A0)});
      tbl.push_back({f_word(A1, 1'b0),              ex(BUSY | WR,          16'hF000, 2'd2, A1)});
      tbl.push_back({f_word(A2, 1'b0),              ex(BUSY | WR,          16'h000F, 2'd2, A2)});
      tbl.push_back({f_word(A3, 1'b0),              ex(F_DONE | BUSY | WR, 16'h00F0, 2'd2, A3)});
      tbl.push_back({r_req(2'd2),                   ex(R_ACK | RD,         16'h0000, 2'd2, A3)});
      // ---- fill/store/read collide; store and read stall behind the fill ----
      tbl.push_back({in_t'(f_req(2'd0, 2'd0) | s_req(2'd1, 2'd3, 4'h6, SD) | r_req(2'd3)),
                                                    ex(F_ACK | BUSY,       16'h0000, 2'd2, A3)});
      tbl.push_back({in_t'(f_word(B0, 1'b0) | s_req(2'd1, 2'd3, 4'h6, SD) | r_req(2'd3)),
                                                    ex(BUSY | WR,          16'h000F, 2'd0, B0)});
      tbl.push_back({in_t'(s_req(2'd1, 2'd3, 4'h6, SD) | r_req(2'd3)),
                                                    ex(BUSY,               16'h0000, 2'd0, B0)});
      tbl.push_back({in_t'(f_word(B1, 1'b0) | s_req(2'd1, 2'd3, 4'h6, SD) | r_req(2'd3)),
                                                    ex(BUSY | WR,          16'h00F0, 2'd0, B1)});
      tbl.push_back({in_t'(f_word(B2, 1'b0) | s_req(2'd1, 2'd3, 4'h6, SD) | r_req(2'd3)),
                                                    ex(BUSY | WR,          16'h0F00, 2'd0, B2)});
      tbl.push_back({in_t'(f_word(B3, 1'b0) | s_req(2'd1, 2'd3, 4'h6, SD) | r_req(2'd3)),
                                                    ex(F_DONE | BUSY | WR, 16'hF000, 2'd0, B3)});
      tbl.push_back({in_t'(s_req(2'd1, 2'd3, 4'h6, SD) | r_req(2'd3)),
                                                    ex(S_ACK | WR,         16'h6000, 2'd1, SD)});
      tbl.push_back({r_req(2'd3),                   ex(R_ACK | RD,         16'h0000, 2'd3, SD)});
      // ---- refill aborted by a bus error on the second word ----
      tbl.push_back({f_req(2'd3, 2'd1),             ex(F_ACK | BUSY,       16'h0000, 2'd3, SD)});
      tbl.push_back({f_word(C0, 1'b0),              ex(BUSY | WR,          16'h00F0, 2'd3, C0)});
      tbl.push_back({f_word(C1, 1'b1),              ex(F_DONE | F_ERR | BUSY, 16'h0000, 2'd3, C0)});
      tbl.push_back({in_t'('0),                     ex(8'h00,              16'h0000, 2'd3, C0)});
      tbl.push_back({in_t'('0),                     ex(8'h00,              16'h0000, 2'd3, C0)});
      // ---- zero-byte-enable store, then back-to-back store and read ----
      tbl.push_back({s_req(2'd2, 2'd1, 4'h0, 32'hEEEE_EEEE),
                                                    ex(S_ACK,              16'h0000, 2'd3, C0)});
      tbl.push_back({s_req(2'd0, 2'd0, 4'h9, DD),   ex(S_ACK | WR,         16'h0009, 2'd0, DD)});
      tbl.push_back({r_req(2'd1),                   ex(R_ACK | RD,         16'h0000, 2'd1, DD)});
      tbl.push_back({in_t'('0),                     ex(8'h00,              16'h0000, 2'd1, DD)});

      foreach (tbl[k]) begin
         apply(tbl[k].i);
         step();
         check($sformatf("vec_%0d", k), 64'(sample()), 64'(tbl[k].o));
      end

      // Line contents as seen by the SRAM (word3..word0).
      check("line2_hi", line_mem[2][127:64], {A1, A0});
      check("line2_lo", line_mem[2][63:0],   {A3, A2});
      check("line0_hi", line_mem[0][127:64], {B3, B2});
      check("line0_lo", line_mem[0][63:0],   {B1, 32'hD100_00D4});
      check("line1_hi", line_mem[1][127:64], {32'h005A_C300, 32'h0});
      check("line3_lo", line_mem[3][63:0],   {C0, 32'h0});

      // ---- reset in the middle of a refill ----
      apply(f_req(2'd1, 2'd3));
      step();
      check("abort_fill_ack", 64'(fill_ack), 64'd1);
      apply(f_word(32'h7777_0000, 1'b0));
      step();
      apply(f_word(32'h7777_0001, 1'b0));
      step();
      apply('0);
      rst_n = 1'b0;
      step();
      check("reset_mid_fill", 64'(sample()), 64'(ex(8'h00, 16'h0, 2'd0, 32'h0)));
      rst_n = 1'b1;
      step();
      check("no_done_after_reset", 64'(sample()), 64'(ex(8'h00, 16'h0, 2'd0, 32'h0)));

      begin
         int k = 0;
         apply(f_req(2'd2, 2'd0));
         do begin
            step();
            k++;
         end while (fill_ack !== 1'b1 && k < 4);
         check("refill_ack_after_reset", 64'(fill_ack), 64'd1);
      end
      for (int w = 0; w < 4; w++) begin
         apply(f_word(32'h9000_0000 + 32'(w), 1'b0));
         step();
         check($sformatf("post_reset_word_%0d", w),
               {30'd0, fill_done, sram_wr_str, sram_wr_mask, 16'd0},
               {30'd0, (w == 3), 1'b1, 16'(16'h000F << (4 * w)), 16'd0});
      end
      apply('0);
      step();
      check("post_reset_idle", 64'({busy, fill_done, sram_wr_str}), 64'd0);

      inv_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
